// File: rtl/demux_row_loader_pkg.sv
// rtl/demux_row_loader_pkg.sv - shared widths, FSM encodings and shift directions for the row loader
package demux_row_loader_pkg;

    localparam int DATAWIDTH_SELECTOR_DEF = 3;
    localparam int DATAWIDTH_DATA_DEF     = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_LOAD    = 2'b01,
        ST_PUBLISH = 2'b10
    } loader_state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/demux_row_shadow.sv
// rtl/demux_row_shadow.sv - write index counter and demultiplexed shadow row register
module demux_row_shadow
    import demux_row_loader_pkg::*;
#(
    parameter int DATAWIDTH_SELECTOR = DATAWIDTH_SELECTOR_DEF,
    parameter int DATAWIDTH_DATA     = DATAWIDTH_DATA_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          beat_en,
    input  logic                          bit_in,
    output logic [DATAWIDTH_SELECTOR-1:0] index,
    output logic [DATAWIDTH_DATA-1:0]     shadow
);

    logic [DATAWIDTH_DATA-1:0] wr_en;

    // One write enable per shadow bit, decoded from the current index
    for (genvar i = 0; i < DATAWIDTH_DATA; i++) begin : g_wr_en
        assign wr_en[i] = beat_en && (index == DATAWIDTH_SELECTOR'(i));
    end

    // Index advances on every accepted beat and wraps naturally after the last bit
    always_ff @(posedge clk) begin
        if (rst) begin
            index <= '0;
        end else if (beat_en) begin
            index <= index + 1'b1;
        end
    end

    // Shadow bits are only rewritten by beats; never cleared after a publish
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
        end else begin
            for (int i = 0; i < DATAWIDTH_DATA; i++) begin
                if (wr_en[i]) begin
                    shadow[i] <= bit_in;
                end
            end
        end
    end

endmodule

// File: rtl/demux_row_loader.sv
// rtl/demux_row_loader.sv - serial-to-parallel row loader with direct write and rotation of the published row
module demux_row_loader
    import demux_row_loader_pkg::*;
#(
    parameter int DATAWIDTH_SELECTOR = DATAWIDTH_SELECTOR_DEF,
    parameter int DATAWIDTH_DATA     = DATAWIDTH_DATA_DEF
) (
    input  logic                          DemuxRow_CLOCK_50,
    input  logic                          DemuxRow_RESET_InHigh,
    input  logic                          DemuxRow_Bit_In,
    input  logic                          DemuxRow_Valid_In,
    output logic                          DemuxRow_Ready_Out,
    input  logic [DATAWIDTH_SELECTOR-1:0] DemuxRow_Select_Bus_In,
    input  logic                          DemuxRow_Write_In,
    input  logic                          DemuxRow_Shift_In,
    input  logic                          DemuxRow_Dir_In,
    output logic [DATAWIDTH_DATA-1:0]     DemuxRow_Data_Bus_Out,
    output logic                          DemuxRow_Done_Out
);

    localparam logic [DATAWIDTH_SELECTOR-1:0] LAST_INDEX = DATAWIDTH_SELECTOR'(DATAWIDTH_DATA - 1);

    loader_state_t                 state_q;
    loader_state_t                 state_d;
    logic                          beat_en;
    logic [DATAWIDTH_SELECTOR-1:0] index;
    logic [DATAWIDTH_DATA-1:0]     shadow;
    logic [DATAWIDTH_DATA-1:0]     rotated_row;
    logic [DATAWIDTH_DATA-1:0]     edited_row;

    assign DemuxRow_Ready_Out = (state_q != ST_PUBLISH);
    assign beat_en            = DemuxRow_Valid_In && DemuxRow_Ready_Out;

    demux_row_shadow #(
        .DATAWIDTH_SELECTOR(DATAWIDTH_SELECTOR),
        .DATAWIDTH_DATA    (DATAWIDTH_DATA)
    ) u_shadow (
        .clk    (DemuxRow_CLOCK_50),
        .rst    (DemuxRow_RESET_InHigh),
        .beat_en(beat_en),
        .bit_in (DemuxRow_Bit_In),
        .index  (index),
        .shadow (shadow)
    );

    // FSM state register
    always_ff @(posedge DemuxRow_CLOCK_50) begin
        if (DemuxRow_RESET_InHigh) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: first beat starts a row, beat at the last index publishes for one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (beat_en) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (beat_en && (index == LAST_INDEX)) begin
                    state_d = ST_PUBLISH;
                end
            end
            ST_PUBLISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Candidate published row: rotate first, then overlay the direct write
    always_comb begin
        rotated_row = '0;
        edited_row  = '0;
        if (DemuxRow_Dir_In == DIR_RIGHT) begin
            rotated_row = {DemuxRow_Data_Bus_Out[0], DemuxRow_Data_Bus_Out[DATAWIDTH_DATA-1:1]};
        end else begin
            rotated_row = {DemuxRow_Data_Bus_Out[DATAWIDTH_DATA-2:0], DemuxRow_Data_Bus_Out[DATAWIDTH_DATA-1]};
        end
        edited_row = DemuxRow_Shift_In ? rotated_row : DemuxRow_Data_Bus_Out;
        if (DemuxRow_Write_In) begin
            edited_row[DemuxRow_Select_Bus_In] = DemuxRow_Bit_In;
        end
    end

    // Published row and done pulse: publish wins and drops any shift/write that cycle
    always_ff @(posedge DemuxRow_CLOCK_50) begin
        if (DemuxRow_RESET_InHigh) begin
            DemuxRow_Data_Bus_Out <= '0;
            DemuxRow_Done_Out     <= 1'b0;
        end else if (state_q == ST_PUBLISH) begin
            DemuxRow_Data_Bus_Out <= shadow;
            DemuxRow_Done_Out     <= 1'b1;
        end else begin
            DemuxRow_Data_Bus_Out <= edited_row;
            DemuxRow_Done_Out     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_demux_row_loader.sv
// tb/tb_demux_row_loader.sv - randomized and directed self-checking bench for demux_row_loader
module tb_demux_row_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_in;
    logic       valid;
    logic       ready;
    logic [2:0] sel;
    logic       wr;
    logic       shift;
    logic       dir;
    logic [7:0] data;
    logic       done;

    int n_compared   = 0;
    int n_mismatched = 0;

    int  m_shadow [8];
    int  m_count;
    bit  m_pending;
    int  m_row;
    int  m_done;
    int  prev_done;

    always #5 clk = ~clk;

    demux_row_loader dut (
        .DemuxRow_CLOCK_50     (clk),
        .DemuxRow_RESET_InHigh (rst),
        .DemuxRow_Bit_In       (bit_in),
        .DemuxRow_Valid_In     (valid),
        .DemuxRow_Ready_Out    (ready),
        .DemuxRow_Select_Bus_In(sel),
        .DemuxRow_Write_In     (wr),
        .DemuxRow_Shift_In     (shift),
        .DemuxRow_Dir_In       (dir),
        .DemuxRow_Data_Bus_Out (data),
        .DemuxRow_Done_Out     (done)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int shadow_value();
        int v = 0;
        for (int i = 0; i < 8; i++) v += m_shadow[i] * (1 << i);
        return v;
    endfunction

    // Behavioural model: beats fill positions in arrival order, the row after the 8th
    // beat is published one cycle later, and that cycle is a bubble ignoring everything else.
    task automatic model_step(input bit r, input bit v, input bit b, input bit w,
                              input int s, input bit sh, input bit d);
        int nxt;
        if (r) begin
            for (int i = 0; i < 8; i++) m_shadow[i] = 0;
            m_count = 0; m_pending = 0; m_row = 0; m_done = 0;
        end else if (m_pending) begin
            m_row = shadow_value();
            m_done = 1;
            m_pending = 0;
        end else begin
            m_done = 0;
            if (v) begin
                m_shadow[m_count] = b;
                m_count++;
                if (m_count == 8) begin
                    m_count = 0;
                    m_pending = 1;
                end
            end
            nxt = m_row;
            if (sh) begin
                if (d) nxt = nxt / 2 + (nxt % 2) * 128;
                else   nxt = (nxt * 2) % 256 + nxt / 128;
            end
            if (w) begin
                if (b) nxt = nxt | (1 << s);
                else   nxt = nxt & ~(1 << s) & 255;
            end
            m_row = nxt;
        end
    endtask

    // One clock: drive at negedge, check ready, advance the model, check registered outputs next negedge
    task automatic cycle(input bit r, input bit v, input bit b, input bit w,
                         input int s, input bit sh, input bit d);
        rst = r; valid = v; bit_in = b; wr = w; sel = 3'(s); shift = sh; dir = d;
        #1;
        check_eq("ready", int'(ready), m_pending ? 0 : 1);
        model_step(r, v, b, w, s, sh, d);
        @(negedge clk);
        check_eq("data", int'(data), m_row);
        check_eq("done", int'(done), m_done);
        if (prev_done == 1 && done === 1'b1) check_eq("done_twice", int'(done), 0);
        prev_done = int'(done);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic load_row(input int value);
        for (int i = 0; i < 8; i++) cycle(0, 1, value[i], 0, 0, 0, 0);
    endtask

    initial begin
        prev_done = 0;
        rst = 1; valid = 0; bit_in = 0; wr = 0; sel = 0; shift = 0; dir = 0;
        @(negedge clk);
        cycle(1, 0, 0, 0, 0, 0, 0);
        check_eq("rst_data", int'(data), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_ready", int'(ready), 1);

        // bits 1,0,1,1,0,0,0,1 -> 8'h8D
        load_row(32'h8D);
        check_eq("t1_ready_low", int'(ready), 0);
        check_eq("t1_data_before", int'(data), 0);
        idle();
        check_eq("t1_data", int'(data), 32'h8D);
        check_eq("t1_done", int'(done), 1);
        check_eq("t1_ready_back", int'(ready), 1);
        idle();
        check_eq("t1_done_off", int'(done), 0);

        // rotation left then right twice
        load_row(32'h81);
        idle();
        check_eq("t2_pub", int'(data), 32'h81);
        cycle(0, 0, 0, 0, 0, 1, 0);
        check_eq("t2_left", int'(data), 32'h03);
        cycle(0, 0, 0, 0, 0, 1, 1);
        check_eq("t2_right1", int'(data), 32'h81);
        cycle(0, 0, 0, 0, 0, 1, 1);
        check_eq("t2_right2", int'(data), 32'hC0);

        // shift and direct write in the same cycle
        load_row(32'h00);
        idle();
        check_eq("t3_pub", int'(data), 32'h00);
        cycle(0, 0, 1, 1, 0, 1, 0);
        check_eq("t3_shift_write", int'(data), 32'h01);

        // shift/write dropped in the publish cycle
        load_row(32'h5A);
        cycle(0, 0, 1, 1, 3, 1, 0);
        check_eq("t4_data", int'(data), 32'h5A);
        check_eq("t4_done", int'(done), 1);

        // reset mid-row, then a full row of ones
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        check_eq("t5_rst_data", int'(data), 0);
        for (int i = 0; i < 7; i++) begin
            cycle(0, 1, 1, 0, 0, 0, 0);
            check_eq("t5_no_done", int'(done), 0);
        end
        cycle(0, 1, 1, 0, 0, 0, 0);
        check_eq("t5_no_done_8th", int'(done), 0);
        idle();
        check_eq("t5_data", int'(data), 32'hFF);
        check_eq("t5_done", int'(done), 1);

        // gapped zeros over a published 8'hFF
        for (int i = 0; i < 8; i++) begin
            cycle(0, 1, 0, 0, 0, 0, 0);
            check_eq("t6_hold", int'(data), 32'hFF);
            if (i < 7) for (int j = 0; j < 3; j++) idle();
        end
        idle();
        check_eq("t6_data", int'(data), 32'h00);
        check_eq("t6_done", int'(done), 1);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 9) < 7),
                  1'($urandom),
                  ($urandom_range(0, 4) == 0),
                  int'($urandom_range(0, 7)),
                  ($urandom_range(0, 4) == 0),
                  1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
